// File: rtl/conv_seq_pkg.sv
// Shared definitions for the conv layer sequencer.
// Contents: sequencer state enum, descriptor field layout, geometry codes
// and a helper that splits a raw 14-bit descriptor word into its fields.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RST,
        WAIT_LOW,
        RUN,
        NEXT,
        DONE,
        ERR
    } seq_state_t;

    // Descriptor word: {out_ch[8:0], img_choose[2:0], chan_choose[1:0]}
    localparam int unsigned DESC_W    = 14;
    localparam int unsigned CHAN_LSB  = 0;
    localparam int unsigned CHAN_W    = 2;
    localparam int unsigned IMG_LSB   = 2;
    localparam int unsigned IMG_W     = 3;
    localparam int unsigned OUTCH_LSB = 5;
    localparam int unsigned OUTCH_W   = 9;

    localparam logic [CHAN_W-1:0] CHAN_256 = 2'd0;
    localparam logic [CHAN_W-1:0] CHAN_128 = 2'd1;
    localparam logic [CHAN_W-1:0] CHAN_64  = 2'd2;

    localparam logic [IMG_W-1:0] IMG_4   = 3'd0;
    localparam logic [IMG_W-1:0] IMG_8   = 3'd1;
    localparam logic [IMG_W-1:0] IMG_16  = 3'd2;
    localparam logic [IMG_W-1:0] IMG_32  = 3'd3;
    localparam logic [IMG_W-1:0] IMG_64  = 3'd4;
    localparam logic [IMG_W-1:0] IMG_128 = 3'd5;

    typedef struct packed {
        logic [OUTCH_W-1:0] out_ch;      // kernels - 1
        logic [IMG_W-1:0]   img_choose;
        logic [CHAN_W-1:0]  chan_choose;
    } desc_t;

    function automatic desc_t unpack_desc(input logic [DESC_W-1:0] raw);
        desc_t d;
        d.out_ch      = raw[OUTCH_LSB +: OUTCH_W];
        d.img_choose  = raw[IMG_LSB +: IMG_W];
        d.chan_choose = raw[CHAN_LSB +: CHAN_W];
        return d;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Host-side bundle of the conv layer sequencer.
// master: host (writes descriptors, starts/aborts, reads status)
// slave : sequencer
//   cfg_we/cfg_addr/cfg_wdata  descriptor table write port
//   num_layers                 layers to run minus 1, sampled on start
//   start/abort                1-cycle command pulses
//   busy/seq_done/seq_err      status levels
//   layer_idx/out_ch_idx       progress
interface conv_layer_sequencer_if #(
    parameter int unsigned MAX_LAYERS = 8
);
    import conv_seq_pkg::*;

    localparam int unsigned LAYER_W = $clog2(MAX_LAYERS);

    logic                 cfg_we;
    logic [LAYER_W-1:0]   cfg_addr;
    logic [DESC_W-1:0]    cfg_wdata;
    logic [LAYER_W-1:0]   num_layers;
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 seq_done;
    logic                 seq_err;
    logic [LAYER_W-1:0]   layer_idx;
    logic [OUTCH_W-1:0]   out_ch_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, num_layers, start, abort,
        input  busy, seq_done, seq_err, layer_idx, out_ch_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, num_layers, start, abort,
        output busy, seq_done, seq_err, layer_idx, out_ch_idx
    );

endinterface

// File: rtl/conv_seq_desc_table.sv
// Layer descriptor register file: MAX_LAYERS entries of one descriptor each.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
// Contents are deliberately not reset; the host loads them before a run.
module conv_seq_desc_table
    import conv_seq_pkg::*;
#(
    parameter int unsigned MAX_LAYERS = 8,
    parameter int unsigned ADDR_W     = $clog2(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DESC_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output desc_t             rdata
);

    desc_t mem [MAX_LAYERS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= unpack_desc(wdata);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Run-time scheduler for the conv top: walks the descriptor table and runs
// one conv pass per output channel of each layer.
// Ports: clk, Reset_top (sync, active high); host (slave modport of
// conv_layer_sequencer_if); conv_DONE from the conv top; conv_Reset_top,
// conv_aresetn, Load_kernel_BRAM, CHANNEL_SIZE_choose, IMAGE_SIZE_choose to it.
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned MAX_LAYERS    = 8,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   Reset_top,
    conv_layer_sequencer_if.slave  host,
    input  logic                   conv_DONE,
    output logic                   conv_Reset_top,
    output logic                   conv_aresetn,
    output logic                   Load_kernel_BRAM,
    output logic [CHAN_W-1:0]      CHANNEL_SIZE_choose,
    output logic [IMG_W-1:0]       IMAGE_SIZE_choose
);

    localparam int unsigned LAYER_W = $clog2(MAX_LAYERS);
    localparam int unsigned RCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_t               state_q, state_d;
    logic [LAYER_W-1:0]       layer_q, layer_d;
    logic [LAYER_W-1:0]       nlayers_q, nlayers_d;
    logic [OUTCH_W-1:0]       och_q, och_d;
    logic [OUTCH_W-1:0]       limit_q, limit_d;
    logic [RCW-1:0]           rst_cnt_q, rst_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic [CHAN_W-1:0]        chan_q, chan_d;
    logic [IMG_W-1:0]         img_q, img_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     conv_rst_q, conv_rst_d;
    logic                     load_q, load_d;
    logic                     busy_q, busy_d;
    desc_t                    cur_desc;

    // Writes are dropped while busy so the table is frozen during a run.
    conv_seq_desc_table #(
        .MAX_LAYERS (MAX_LAYERS)
    ) u_table (
        .clk   (clk),
        .we    (host.cfg_we && !busy_q),
        .waddr (host.cfg_addr),
        .wdata (host.cfg_wdata),
        .raddr (layer_q),
        .rdata (cur_desc)
    );

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        nlayers_d = nlayers_q;
        och_d     = och_q;
        limit_d   = limit_q;
        rst_cnt_d = rst_cnt_q;
        wd_d      = wd_q;
        chan_d    = chan_q;
        img_d     = img_q;
        done_d    = done_q;
        err_d     = err_q;

        if (host.abort) begin
            // abort outranks start and any state-local decision
            state_d = IDLE;
            layer_d = '0;
            och_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (host.start) begin
                        state_d   = FETCH;
                        layer_d   = '0;
                        och_d     = '0;
                        nlayers_d = host.num_layers;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                    end
                end
                FETCH: begin
                    chan_d    = cur_desc.chan_choose;
                    img_d     = cur_desc.img_choose;
                    limit_d   = cur_desc.out_ch;
                    rst_cnt_d = '0;
                    state_d   = RST;
                end
                RST: begin
                    if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOW;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    // a DONE left high from the previous pass must drop first
                    wd_d = '0;
                    if (!conv_DONE) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (conv_DONE) begin
                        state_d = NEXT;
                    end else begin
                        wd_d = wd_q + 1'b1;
                        if (wd_d == '1) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (och_q < limit_q) begin
                        och_d     = och_q + 1'b1;
                        rst_cnt_d = '0;
                        state_d   = RST;
                    end else if (layer_q < nlayers_q) begin
                        layer_d = layer_q + 1'b1;
                        och_d   = '0;
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // outputs decoded from the next state so they leave a flop directly
        conv_rst_d = !(state_d inside {WAIT_LOW, RUN});
        load_d     = (state_d == RUN);
        busy_d     = state_d inside {FETCH, RST, WAIT_LOW, RUN, NEXT};
    end

    always_ff @(posedge clk) begin
        if (Reset_top) begin
            state_q    <= IDLE;
            layer_q    <= '0;
            nlayers_q  <= '0;
            och_q      <= '0;
            limit_q    <= '0;
            rst_cnt_q  <= '0;
            wd_q       <= '0;
            chan_q     <= '0;
            img_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            conv_rst_q <= 1'b1;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            nlayers_q  <= nlayers_d;
            och_q      <= och_d;
            limit_q    <= limit_d;
            rst_cnt_q  <= rst_cnt_d;
            wd_q       <= wd_d;
            chan_q     <= chan_d;
            img_q      <= img_d;
            done_q     <= done_d;
            err_q      <= err_d;
            conv_rst_q <= conv_rst_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
        end
    end

    assign conv_Reset_top      = conv_rst_q;
    assign conv_aresetn        = ~conv_rst_q;
    assign Load_kernel_BRAM    = load_q;
    assign CHANNEL_SIZE_choose = chan_q;
    assign IMAGE_SIZE_choose   = img_q;
    assign host.busy           = busy_q;
    assign host.seq_done       = done_q;
    assign host.seq_err        = err_q;
    assign host.layer_idx      = layer_q;
    assign host.out_ch_idx     = och_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
module tb_conv_layer_sequencer;
    import conv_seq_pkg::*;

    localparam int ML     = 8;
    localparam int RC     = 4;
    localparam int TW     = 8;
    localparam int CONV_LAT = 50;
    localparam int BUDGET = 20000;

    typedef struct {
        int l;
        int k;
        int chan;
        int img;
        int gap;
    } pass_t;

    logic       clk = 1'b0;
    logic       Reset_top;
    logic       conv_DONE;
    logic       conv_Reset_top;
    logic       conv_aresetn;
    logic       Load_kernel_BRAM;
    logic [1:0] CHANNEL_SIZE_choose;
    logic [2:0] IMAGE_SIZE_choose;

    int errors = 0;
    int checks = 0;

    // reference copy of the descriptor table
    int t_och  [ML];
    int t_img  [ML];
    int t_chan [ML];

    // conv top model: raises DONE after CONV_LAT load cycles, cleared by its reset
    bit force_done = 1'b0;
    bit never_done = 1'b0;
    bit done_int   = 1'b0;
    int load_cnt   = 0;

    always #5 clk = ~clk;

    conv_layer_sequencer_if #(.MAX_LAYERS(ML)) host ();

    conv_layer_sequencer #(
        .MAX_LAYERS    (ML),
        .RST_CYCLES    (RC),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk                 (clk),
        .Reset_top           (Reset_top),
        .host                (host),
        .conv_DONE           (conv_DONE),
        .conv_Reset_top      (conv_Reset_top),
        .conv_aresetn        (conv_aresetn),
        .Load_kernel_BRAM    (Load_kernel_BRAM),
        .CHANNEL_SIZE_choose (CHANNEL_SIZE_choose),
        .IMAGE_SIZE_choose   (IMAGE_SIZE_choose)
    );

    assign conv_DONE = force_done | done_int;

    always @(negedge clk) begin
        if (conv_Reset_top === 1'b1) begin
            load_cnt = 0;
            done_int = 1'b0;
        end else if (Load_kernel_BRAM === 1'b1) begin
            load_cnt++;
            if (!never_done && load_cnt >= CONV_LAT) done_int = 1'b1;
        end
    end

    task automatic write_desc(input int a, input int och, input int img, input int chan, input bit shadow);
        host.cfg_we    = 1'b1;
        host.cfg_addr  = a[2:0];
        host.cfg_wdata = {och[8:0], img[2:0], chan[1:0]};
        @(negedge clk);
        host.cfg_we = 1'b0;
        if (shadow) begin
            t_och[a]  = och;
            t_img[a]  = img;
            t_chan[a] = chan;
        end
    endtask

    task automatic pulse_start(input int nl);
        host.num_layers = nl[2:0];
        host.start      = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 3000; c++) begin
            if (host.busy === 1'b0) break;
            @(negedge clk);
        end
        checks++;
        if (host.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b, expected 0 within budget", tag, host.busy);
        end
    endtask

    // Starts a run of nl+1 layers and compares the observed pass sequence
    // with the one implied by the reference table.
    task automatic run_seq(input int nl, input string tag);
        pass_t exp_q[$];
        pass_t got_q[$];
        int hi = 0, last_gap = 0, unstable = 0, n;
        bit pl = 1'b0, pr, ended = 1'b0;
        logic [1:0] pc;
        logic [2:0] pi;

        for (int l = 0; l <= nl; l++)
            for (int k = 0; k <= t_och[l]; k++)
                // between passes of one layer: one NEXT cycle plus RC reset cycles
                exp_q.push_back(pass_t'{l, k, t_chan[l], t_img[l], (k > 0) ? RC + 1 : -1});

        pulse_start(nl);
        pc = CHANNEL_SIZE_choose;
        pi = IMAGE_SIZE_choose;
        pr = conv_Reset_top;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (!conv_Reset_top && (CHANNEL_SIZE_choose !== pc || IMAGE_SIZE_choose !== pi)) unstable++;
            if (conv_Reset_top) hi++;
            else if (pr) begin
                last_gap = hi;
                hi = 0;
            end
            if (Load_kernel_BRAM && !pl)
                got_q.push_back(pass_t'{int'(host.layer_idx), int'(host.out_ch_idx),
                                        int'(CHANNEL_SIZE_choose), int'(IMAGE_SIZE_choose), last_gap});
            pc = CHANNEL_SIZE_choose;
            pi = IMAGE_SIZE_choose;
            pr = conv_Reset_top;
            pl = Load_kernel_BRAM;
            if (host.busy !== 1'b1) begin
                ended = 1'b1;
                break;
            end
        end

        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL %s_end: run still busy after %0d cycles, expected to finish", tag, BUDGET);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_pass_count: got %0d passes, expected %0d", tag, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i].l !== exp_q[i].l || got_q[i].k !== exp_q[i].k ||
                got_q[i].chan !== exp_q[i].chan || got_q[i].img !== exp_q[i].img ||
                (exp_q[i].gap >= 0 && got_q[i].gap !== exp_q[i].gap)) begin
                errors++;
                $display("FAIL %s_pass%0d: got l=%0d k=%0d chan=%0d img=%0d rstgap=%0d, expected l=%0d k=%0d chan=%0d img=%0d rstgap=%0d",
                         tag, i, got_q[i].l, got_q[i].k, got_q[i].chan, got_q[i].img, got_q[i].gap,
                         exp_q[i].l, exp_q[i].k, exp_q[i].chan, exp_q[i].img, exp_q[i].gap);
            end
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL %s_geometry_stable: %0d changes outside reset, expected 0", tag, unstable);
        end
        checks++;
        if (host.seq_done !== 1'b1 || host.busy !== 1'b0 || host.seq_err !== 1'b0 ||
            Load_kernel_BRAM !== 1'b0 || conv_Reset_top !== 1'b1) begin
            errors++;
            $display("FAIL %s_final_status: done=%b busy=%b err=%b load=%b rst=%b, expected 1 0 0 0 1",
                     tag, host.seq_done, host.busy, host.seq_err, Load_kernel_BRAM, conv_Reset_top);
        end
        checks++;
        if (int'(host.layer_idx) !== nl || int'(host.out_ch_idx) !== t_och[nl]) begin
            errors++;
            $display("FAIL %s_final_idx: layer=%0d och=%0d, expected layer=%0d och=%0d",
                     tag, host.layer_idx, host.out_ch_idx, nl, t_och[nl]);
        end
    endtask

    task automatic test_reset;
        Reset_top = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (conv_Reset_top !== 1'b1 || conv_aresetn !== 1'b0 || Load_kernel_BRAM !== 1'b0) begin
            errors++;
            $display("FAIL reset_conv_ctrl: rst=%b aresetn=%b load=%b, expected 1 0 0",
                     conv_Reset_top, conv_aresetn, Load_kernel_BRAM);
        end
        checks++;
        if (CHANNEL_SIZE_choose !== 2'd0 || IMAGE_SIZE_choose !== 3'd0) begin
            errors++;
            $display("FAIL reset_choose: chan=%0d img=%0d, expected 0 0", CHANNEL_SIZE_choose, IMAGE_SIZE_choose);
        end
        checks++;
        if (host.busy !== 1'b0 || host.seq_done !== 1'b0 || host.seq_err !== 1'b0 ||
            host.layer_idx !== 3'd0 || host.out_ch_idx !== 9'd0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b err=%b layer=%0d och=%0d, expected all 0",
                     host.busy, host.seq_done, host.seq_err, host.layer_idx, host.out_ch_idx);
        end
        Reset_top = 1'b0;
        for (int a = 0; a < ML; a++)
            write_desc(a, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2), 1'b1);
    endtask

    task automatic test_single_layer;
        write_desc(0, 2, int'(IMG_4), int'(CHAN_64), 1'b1);
        run_seq(0, "single");
    endtask

    task automatic test_multi_layer;
        write_desc(0, $urandom_range(0, 2), int'(IMG_128), int'(CHAN_256), 1'b1);
        write_desc(1, $urandom_range(0, 2), int'(IMG_32),  int'(CHAN_128), 1'b1);
        write_desc(2, $urandom_range(0, 2), int'(IMG_4),   int'(CHAN_64),  1'b1);
        run_seq(2, "multi");
    endtask

    task automatic test_random_runs;
        for (int r = 0; r < 2; r++) begin
            int nl = $urandom_range(0, ML - 1);
            for (int a = 0; a <= nl; a++)
                write_desc(a, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2), 1'b1);
            run_seq(nl, "random");
        end
    endtask

    task automatic test_stale_done;
        int loads = 0;
        bit low = 1'b0;
        write_desc(0, 0, int'(IMG_16), int'(CHAN_128), 1'b1);
        force_done = 1'b1;
        pulse_start(0);
        for (int c = 0; c < 20; c++) begin
            if (conv_Reset_top === 1'b0) begin
                low = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!low) begin
            errors++;
            $display("FAIL stale_reset_release: conv_Reset_top=%b, expected 0 within 20 cycles", conv_Reset_top);
        end
        repeat (30) begin
            @(negedge clk);
            if (Load_kernel_BRAM !== 1'b0) loads++;
        end
        checks++;
        if (loads !== 0 || conv_Reset_top !== 1'b0 || host.busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_hold: load_cycles=%0d rst=%b busy=%b, expected 0 0 1", loads, conv_Reset_top, host.busy);
        end
        force_done = 1'b0;
        low = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (Load_kernel_BRAM === 1'b1) begin
                low = 1'b1;
                break;
            end
        end
        checks++;
        if (!low) begin
            errors++;
            $display("FAIL stale_release_run: load=%b, expected 1 within 5 cycles of DONE dropping", Load_kernel_BRAM);
        end
        wait_idle("stale");
        checks++;
        if (host.seq_done !== 1'b1) begin
            errors++;
            $display("FAIL stale_done: seq_done=%b, expected 1", host.seq_done);
        end
    endtask

    task automatic test_timeout;
        int runs = 0;
        write_desc(0, 0, int'(IMG_8), int'(CHAN_256), 1'b1);
        never_done = 1'b1;
        pulse_start(0);
        for (int c = 0; c < 1000; c++) begin
            if (host.seq_err === 1'b1) break;
            if (Load_kernel_BRAM === 1'b1) runs++;
            @(negedge clk);
        end
        checks++;
        if (host.seq_err !== 1'b1 || runs !== (1 << TW) - 1) begin
            errors++;
            $display("FAIL timeout_fire: seq_err=%b run_cycles=%0d, expected 1 and %0d", host.seq_err, runs, (1 << TW) - 1);
        end
        checks++;
        if (Load_kernel_BRAM !== 1'b0 || conv_Reset_top !== 1'b1 || host.busy !== 1'b0 || host.seq_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_outputs: load=%b rst=%b busy=%b done=%b, expected 0 1 0 0",
                     Load_kernel_BRAM, conv_Reset_top, host.busy, host.seq_done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (host.seq_err !== 1'b1 || host.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: seq_err=%b busy=%b, expected 1 0", host.seq_err, host.busy);
        end
        never_done = 1'b0;
        pulse_start(0);
        checks++;
        if (host.seq_err !== 1'b0 || host.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart: seq_err=%b busy=%b, expected 0 1", host.seq_err, host.busy);
        end
        wait_idle("timeout_restart");
    endtask

    task automatic test_abort;
        bit hit = 1'b0;
        write_desc(0, 1, int'(IMG_64), int'(CHAN_64), 1'b1);
        write_desc(1, 2, int'(IMG_16), int'(CHAN_128), 1'b1);
        pulse_start(1);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (Load_kernel_BRAM === 1'b1 && host.layer_idx === 3'd1 && host.out_ch_idx === 9'd1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach: layer=%0d och=%0d, expected to reach layer 1 pass 1", host.layer_idx, host.out_ch_idx);
        end
        repeat (10) @(negedge clk);
        host.abort = 1'b1;
        @(negedge clk);
        host.abort = 1'b0;
        checks++;
        if (host.busy !== 1'b0 || conv_Reset_top !== 1'b1 || Load_kernel_BRAM !== 1'b0 || host.seq_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_status: busy=%b rst=%b load=%b done=%b, expected 0 1 0 0",
                     host.busy, conv_Reset_top, Load_kernel_BRAM, host.seq_done);
        end
        checks++;
        if (host.layer_idx !== 3'd0 || host.out_ch_idx !== 9'd0) begin
            errors++;
            $display("FAIL abort_idx: layer=%0d och=%0d, expected 0 0", host.layer_idx, host.out_ch_idx);
        end
        host.start = 1'b1;
        host.abort = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        host.abort = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (host.busy !== 1'b0 || conv_Reset_top !== 1'b1 || host.seq_done !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_same_cycle: busy=%b rst=%b done=%b, expected 0 1 0",
                     host.busy, conv_Reset_top, host.seq_done);
        end
    endtask

    task automatic test_frozen_table;
        bit hit = 1'b0;
        write_desc(0, 1, int'(IMG_32), int'(CHAN_64), 1'b1);
        pulse_start(0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (Load_kernel_BRAM === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL frozen_run_start: load=%b, expected 1 within 100 cycles", Load_kernel_BRAM);
        end
        // dropped write: the reference table is deliberately not updated
        write_desc(0, 3, int'(IMG_128), int'(CHAN_256), 1'b0);
        wait_idle("frozen_first");
        run_seq(0, "frozen_rerun");
    endtask

    initial begin
        Reset_top       = 1'b1;
        host.cfg_we     = 1'b0;
        host.cfg_addr   = '0;
        host.cfg_wdata  = '0;
        host.num_layers = '0;
        host.start      = 1'b0;
        host.abort      = 1'b0;
        test_reset();
        test_single_layer();
        test_multi_layer();
        test_stale_done();
        test_timeout();
        test_abort();
        test_frozen_table();
        test_random_runs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
